// File: rtl/mc_pkg.sv
// mc_pkg: shared geometry/state types and burst-length helper for the address mapper
package mc_pkg;
  typedef enum logic [2:0] {R11, R12, R13, R14, R15} row_widths;
  typedef enum logic [1:0] {C9, C10, C11} col_widths;
  typedef enum logic {IDLE, ISSUE} map_state_e;
  function automatic logic [31:0] burst_count(input logic [7:0] len, input int bb, input int cb);
    return ((32'(len) + 32'd1) * 32'(bb) + 32'(cb) - 32'd1) / 32'(cb);
  endfunction
endpackage

// File: rtl/addr_field_decode.sv
// addr_field_decode: splits a byte address into SDRAM column/row/bank/rank fields
// ADDR_MAPPER_BANK_XOR_EN: bank is XORed with the low row bits
module addr_field_decode
  import mc_pkg::*;
#(
  parameter int AW     = 32,
  parameter int DQ_W   = 16,
  parameter int ROW_W  = 16,
  parameter int BANK_W = 3,
  parameter int CS_W   = 1
) (
  input  logic [AW-1:0]     addr,
  input  row_widths         r_width,
  input  col_widths         c_width,
  input  logic              bor,
  output logic [CS_W-1:0]   rank,
  output logic [BANK_W-1:0] bank,
  output logic [ROW_W-1:0]  row,
  output logic [11:0]       column
);
  localparam int OB = $clog2(DQ_W / 8);
  logic [3:0] cw, rw;
  logic [AW-1:0] a, r_sh, h;
  logic [ROW_W-1:0] row_d;
  logic [BANK_W-1:0] bank_d;
  always_comb begin
    cw = 4'd9 + 4'(c_width);
    rw = 4'd11 + 4'(r_width);
    a = addr >> OB;
    r_sh = a >> cw;
    h = r_sh >> rw;
    column = 12'(a & ((AW'(1) << cw) - AW'(1)));
    row_d = ROW_W'(r_sh & ((AW'(1) << rw) - AW'(1)));
    bank_d = bor ? BANK_W'(h >> CS_W) : BANK_W'(h);
    rank = bor ? CS_W'(h) : CS_W'(h >> BANK_W);
    row = row_d;
`ifdef ADDR_MAPPER_BANK_XOR_EN
    bank = bank_d ^ row_d[BANK_W-1:0];
`else
    bank = bank_d;
`endif
  end
endmodule

// File: rtl/burst_address_mapper.sv
// burst_address_mapper: splits an INCR burst into per-column SDRAM commands
// ADDR_MAPPER_BANK_XOR_EN (in addr_field_decode): bank/row XOR swizzle
module burst_address_mapper
  import mc_pkg::*;
#(
  parameter int C_NASTI_ADDR_WIDTH = 32,
  parameter int C_NASTI_DATA_WIDTH = 64,
  parameter int C_NASTI_ID_WIDTH   = 4,
  parameter int C_CS_WIDTH         = 1,
  parameter int C_DQ_WIDTH         = 16,
  parameter int C_ROW_WIDTH        = 16,
  parameter int C_BANK_WIDTH       = 3,
  parameter int C_BL               = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  row_widths                     r_width,
  input  col_widths                     c_width,
  input  logic                          bor,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [C_NASTI_ADDR_WIDTH-1:0] req_addr,
  input  logic [7:0]                    req_len,
  input  logic [C_NASTI_ID_WIDTH-1:0]   req_id,
  output logic                          cmd_valid,
  input  logic                          cmd_ready,
  output logic [C_CS_WIDTH-1:0]         cmd_rank,
  output logic [C_BANK_WIDTH-1:0]       cmd_bank,
  output logic [C_ROW_WIDTH-1:0]        cmd_row,
  output logic [11:0]                   cmd_column,
  output logic [C_NASTI_ID_WIDTH-1:0]   cmd_id,
  output logic                          cmd_last
);
  localparam int AW = C_NASTI_ADDR_WIDTH;
  localparam int BB = C_NASTI_DATA_WIDTH / 8;
  localparam int CB = C_BL * C_DQ_WIDTH / 8;
  localparam logic [AW-1:0] ALIGN = ~AW'(CB - 1);
  localparam logic [AW-1:0] STEP = AW'(CB);
  map_state_e state, nxt;
  logic [AW-1:0] addr_q;
  logic [31:0] cnt;
  logic [C_NASTI_ID_WIDTH-1:0] id_q;
  row_widths r_q;
  col_widths c_q;
  logic bor_q;
  assign req_ready = state == IDLE;
  assign cmd_valid = state == ISSUE;
  assign cmd_last = cmd_valid && cnt == 32'd1;
  assign cmd_id = id_q;
  always_comb
    nxt = state == IDLE ? (req_valid ? ISSUE : IDLE)
                        : (cmd_valid && cmd_ready && cmd_last ? IDLE : ISSUE);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // geometry is captured with the request so the in-flight burst ignores later changes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr_q <= '0;
      cnt <= '0;
      id_q <= '0;
      r_q <= R11;
      c_q <= C9;
      bor_q <= 1'b0;
    end else if (req_valid && req_ready) begin
      addr_q <= req_addr & ALIGN;
      cnt <= burst_count(req_len, BB, CB);
      id_q <= req_id;
      r_q <= r_width;
      c_q <= c_width;
      bor_q <= bor;
    end else if (cmd_valid && cmd_ready) begin
      addr_q <= addr_q + STEP;
      cnt <= cnt - 32'd1;
    end
  addr_field_decode #(
    .AW(AW), .DQ_W(C_DQ_WIDTH), .ROW_W(C_ROW_WIDTH), .BANK_W(C_BANK_WIDTH), .CS_W(C_CS_WIDTH)
  ) u_dec (
    .addr(addr_q), .r_width(r_q), .c_width(c_q), .bor(bor_q),
    .rank(cmd_rank), .bank(cmd_bank), .row(cmd_row), .column(cmd_column)
  );
endmodule

// File: tb/tb_burst_address_mapper.sv
// tb_burst_address_mapper: directed checks of command generation, stalls, reset and decode
module tb_burst_address_mapper;
  import mc_pkg::*;
  logic clk = 0;
  logic rst_n;
  row_widths r_width;
  col_widths c_width;
  logic bor, req_valid, req_ready, cmd_valid, cmd_ready, cmd_last;
  logic [31:0] req_addr;
  logic [7:0] req_len;
  logic [3:0] req_id, cmd_id;
  logic [0:0] cmd_rank;
  logic [2:0] cmd_bank;
  logic [15:0] cmd_row;
  logic [11:0] cmd_column;
  int checks = 0;
  int failures = 0;
  logic [31:0] xor_bank;

  burst_address_mapper dut (
    .clk(clk), .rst_n(rst_n), .r_width(r_width), .c_width(c_width), .bor(bor),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .req_id(req_id), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rank(cmd_rank),
    .cmd_bank(cmd_bank), .cmd_row(cmd_row), .cmd_column(cmd_column), .cmd_id(cmd_id),
    .cmd_last(cmd_last)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [31:0] a, input logic [7:0] l, input logic [3:0] id);
    req_addr = a;
    req_len = l;
    req_id = id;
    req_valid = 1;
    chk("accept_ready", 32'(req_ready), 1);
    step();
    req_valid = 0;
  endtask

  initial begin
`ifdef ADDR_MAPPER_BANK_XOR_EN
    xor_bank = 5;
`else
    xor_bank = 0;
`endif
    rst_n = 0; r_width = R14; c_width = C10; bor = 0;
    req_valid = 0; req_addr = 0; req_len = 0; req_id = 0; cmd_ready = 1;
    #1;
    chk("rst_valid", 32'(cmd_valid), 0);
    chk("rst_last", 32'(cmd_last), 0);
    chk("rst_col", 32'(cmd_column), 0);
    chk("rst_row", 32'(cmd_row), 0);
    chk("rst_id", 32'(cmd_id), 0);
    step(); step();
    rst_n = 1;
    step();
    chk("post_rst_ready", 32'(req_ready), 1);

    accept(32'h0, 8'd3, 4'd5);
    chk("t1_valid", 32'(cmd_valid), 1);
    chk("t1_ready0", 32'(req_ready), 0);
    chk("t1_col0", 32'(cmd_column), 32'h000);
    chk("t1_row0", 32'(cmd_row), 0);
    chk("t1_last0", 32'(cmd_last), 0);
    chk("t1_id0", 32'(cmd_id), 5);
    step();
    chk("t1_col1", 32'(cmd_column), 32'h008);
    chk("t1_last1", 32'(cmd_last), 1);
    chk("t1_id1", 32'(cmd_id), 5);
    step();
    chk("t1_idle_valid", 32'(cmd_valid), 0);
    chk("t1_idle_ready", 32'(req_ready), 1);

    accept(32'h7F0, 8'd3, 4'd2);
    chk("t2_row0", 32'(cmd_row), 0);
    chk("t2_col0", 32'(cmd_column), 32'h3F8);
    chk("t2_last0", 32'(cmd_last), 0);
    step();
    chk("t2_row1", 32'(cmd_row), 1);
    chk("t2_col1", 32'(cmd_column), 0);
    chk("t2_last1", 32'(cmd_last), 1);
    step();

    accept(32'h1000_0000, 8'd0, 4'd1);
    chk("t3_rank", 32'(cmd_rank), 1);
    chk("t3_bank", 32'(cmd_bank), 0);
    chk("t3_last", 32'(cmd_last), 1);
    step();
    bor = 1;
    accept(32'h1000_0000, 8'd0, 4'd1);
    chk("t3_bor_rank", 32'(cmd_rank), 0);
    chk("t3_bor_bank", 32'(cmd_bank), 4);
    step();
    bor = 0;

    accept(32'h100, 8'd7, 4'd9);
    chk("t4_col0", 32'(cmd_column), 32'h080);
    step();
    chk("t4_col1", 32'(cmd_column), 32'h088);
    cmd_ready = 0;
    c_width = C9;
    bor = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_stall_valid", 32'(cmd_valid), 1);
      chk("t4_stall_col", 32'(cmd_column), 32'h088);
      chk("t4_stall_ready", 32'(req_ready), 0);
      chk("t4_stall_last", 32'(cmd_last), 0);
      chk("t4_stall_id", 32'(cmd_id), 9);
    end
    cmd_ready = 1;
    step();
    chk("t4_col2", 32'(cmd_column), 32'h090);
    chk("t4_last2", 32'(cmd_last), 0);
    step();
    chk("t4_col3", 32'(cmd_column), 32'h098);
    chk("t4_last3", 32'(cmd_last), 1);
    step();
    chk("t4_idle", 32'(cmd_valid), 0);
    c_width = C10;
    bor = 0;

    accept(32'h0, 8'd7, 4'd3);
    chk("t5_first", 32'(cmd_valid), 1);
    step();
    chk("t5_second_col", 32'(cmd_column), 32'h008);
    rst_n = 0;
    #1;
    chk("t5_rst_valid", 32'(cmd_valid), 0);
    chk("t5_rst_last", 32'(cmd_last), 0);
    chk("t5_rst_col", 32'(cmd_column), 0);
    chk("t5_rst_id", 32'(cmd_id), 0);
    step();
    rst_n = 1;
    step();
    chk("t5_after_ready", 32'(req_ready), 1);
    chk("t5_after_valid", 32'(cmd_valid), 0);
    step();
    chk("t5_still_idle", 32'(cmd_valid), 0);

    accept(32'h2800, 8'd0, 4'd0);
    chk("t6_row", 32'(cmd_row), 5);
    chk("t6_bank", 32'(cmd_bank), xor_bank);
    step();

    accept(32'hFFFF_FFF0, 8'd3, 4'd7);
    chk("t7_col0", 32'(cmd_column), 32'h3F8);
    chk("t7_row0", 32'(cmd_row), 32'h3FFF);
    chk("t7_rank0", 32'(cmd_rank), 1);
    step();
    chk("t7_wrap_col", 32'(cmd_column), 0);
    chk("t7_wrap_row", 32'(cmd_row), 0);
    chk("t7_wrap_rank", 32'(cmd_rank), 0);
    chk("t7_wrap_last", 32'(cmd_last), 1);
    step();

    c_width = C11;
    accept(32'h808, 8'd0, 4'd4);
    chk("t8_c11_col", 32'(cmd_column), 32'h400);
    chk("t8_c11_row", 32'(cmd_row), 0);
    step();
    chk("t8_idle", 32'(cmd_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
